// File: rtl/mem_ctrl_pkg.sv
// Shared types, constants and lane helpers for the data-memory access controller.
// Lane k of a 32-bit little-endian word occupies bits 8k+7:8k.
package mem_ctrl_pkg;

    localparam int DATA_LENGTH = 32;
    localparam int BYTE_LENGTH = 8;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACCESS = 2'b01,
        WRITE  = 2'b10,
        RESP   = 2'b11
    } state_t;

    // Illegal size or an address not aligned to the access size.
    function automatic logic req_error(input logic [1:0] size, input logic [1:0] offset);
        logic err;
        case (size)
            SZ_BYTE: err = 1'b0;
            SZ_HALF: err = offset[0];
            SZ_WORD: err = (offset != 2'b00);
            default: err = 1'b1;
        endcase
        return err;
    endfunction

    function automatic logic [DATA_LENGTH-1:0] merge_lanes(
        input logic [DATA_LENGTH-1:0] word,
        input logic [DATA_LENGTH-1:0] wdata,
        input logic [1:0]             size,
        input logic [1:0]             offset
    );
        logic [DATA_LENGTH-1:0] merged;
        merged = word;
        case (size)
            SZ_BYTE: merged[{offset, 3'b000} +: BYTE_LENGTH]     = wdata[BYTE_LENGTH-1:0];
            SZ_HALF: merged[{offset[1], 4'b0000} +: 2*BYTE_LENGTH] = wdata[2*BYTE_LENGTH-1:0];
            default: merged = wdata;
        endcase
        return merged;
    endfunction

    function automatic logic [DATA_LENGTH-1:0] load_extend(
        input logic [DATA_LENGTH-1:0] word,
        input logic [1:0]             size,
        input logic [1:0]             offset,
        input logic                   is_unsigned
    );
        logic [BYTE_LENGTH-1:0]   b;
        logic [2*BYTE_LENGTH-1:0] h;
        logic [DATA_LENGTH-1:0]   res;
        b = word[{offset, 3'b000} +: BYTE_LENGTH];
        h = word[{offset[1], 4'b0000} +: 2*BYTE_LENGTH];
        case (size)
            SZ_BYTE: res = is_unsigned ? {{(DATA_LENGTH-BYTE_LENGTH){1'b0}}, b}
                                       : {{(DATA_LENGTH-BYTE_LENGTH){b[BYTE_LENGTH-1]}}, b};
            SZ_HALF: res = is_unsigned ? {{(DATA_LENGTH-2*BYTE_LENGTH){1'b0}}, h}
                                       : {{(DATA_LENGTH-2*BYTE_LENGTH){h[2*BYTE_LENGTH-1]}}, h};
            default: res = word;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/mem_rr_arbiter.sv
// Two-way round-robin arbiter (bit 0 = cpu, bit 1 = dbg). Any grant is an accept,
// because the granted port's ready is the grant itself.
module mem_rr_arbiter (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] valid,
    input  logic       enable,
    output logic [1:0] grant
);

    // 0 = cpu won last, 1 = dbg won last; reset to dbg so cpu wins the first tie.
    logic last_grant_reg;

    always_comb begin
        grant = 2'b00;
        if (enable) begin
            case (valid)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = last_grant_reg ? 2'b01 : 2'b10;
                default: grant = 2'b00;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_reg <= 1'b1;
        end else if (|grant) begin
            last_grant_reg <= grant[1];
        end
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// Shares a word-wide, byte-addressed data memory between the cpu and dbg ports;
// sub-word stores are done as read-modify-write, sub-word loads are extended.
module mem_access_ctrl #(
    parameter int N           = 8,
    parameter int DATA_LENGTH = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,

    input  logic                   cpu_req_valid,
    output logic                   cpu_req_ready,
    input  logic                   cpu_req_we,
    input  logic [1:0]             cpu_req_size,
    input  logic                   cpu_req_unsigned,
    input  logic [N-1:0]           cpu_req_addr,
    input  logic [DATA_LENGTH-1:0] cpu_req_wdata,
    output logic                   cpu_rsp_valid,
    output logic [DATA_LENGTH-1:0] cpu_rsp_rdata,
    output logic                   cpu_rsp_err,

    input  logic                   dbg_req_valid,
    output logic                   dbg_req_ready,
    input  logic                   dbg_req_we,
    input  logic [1:0]             dbg_req_size,
    input  logic                   dbg_req_unsigned,
    input  logic [N-1:0]           dbg_req_addr,
    input  logic [DATA_LENGTH-1:0] dbg_req_wdata,
    output logic                   dbg_rsp_valid,
    output logic [DATA_LENGTH-1:0] dbg_rsp_rdata,
    output logic                   dbg_rsp_err,

    output logic                   mem_wr_en,
    output logic [N-1:0]           mem_w_addr,
    output logic [N-1:0]           mem_r_addr,
    output logic [DATA_LENGTH-1:0] mem_w_data,
    input  logic [DATA_LENGTH-1:0] mem_r_data
);

    import mem_ctrl_pkg::*;

    state_t                 state_reg, state_next;
    logic                   port_reg;       // 0 = cpu, 1 = dbg
    logic                   we_reg;
    logic [1:0]             size_reg;
    logic                   uns_reg;
    logic [N-1:0]           addr_reg;
    logic [DATA_LENGTH-1:0] wdata_reg;
    logic                   err_reg;
    logic [DATA_LENGTH-1:0] rdata_reg;
    logic [DATA_LENGTH-1:0] merged_reg;

    logic [1:0]             grant;
    logic                   sel_we;
    logic [1:0]             sel_size;
    logic                   sel_uns;
    logic [N-1:0]           sel_addr;
    logic [DATA_LENGTH-1:0] sel_wdata;
    logic                   sel_err;
    logic [N-1:0]           aligned_addr;
    logic                   word_store;

    mem_rr_arbiter u_arb (
        .clk    (clk),
        .rst_n  (rst_n),
        .valid  ({dbg_req_valid, cpu_req_valid}),
        .enable (state_reg == IDLE),
        .grant  (grant)
    );

    assign cpu_req_ready = grant[0];
    assign dbg_req_ready = grant[1];

    always_comb begin
        sel_we    = grant[1] ? dbg_req_we       : cpu_req_we;
        sel_size  = grant[1] ? dbg_req_size     : cpu_req_size;
        sel_uns   = grant[1] ? dbg_req_unsigned : cpu_req_unsigned;
        sel_addr  = grant[1] ? dbg_req_addr     : cpu_req_addr;
        sel_wdata = grant[1] ? dbg_req_wdata    : cpu_req_wdata;
        sel_err   = req_error(sel_size, sel_addr[1:0]);
    end

    assign aligned_addr = {addr_reg[N-1:2], 2'b00};
    assign word_store   = we_reg && (size_reg == SZ_WORD);

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (|grant) state_next = sel_err ? RESP : ACCESS;
            ACCESS:  state_next = (we_reg && !word_store) ? WRITE : RESP;
            WRITE:   state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Memory side is decoded from state only, so reset drops mem_wr_en at once.
    always_comb begin
        mem_wr_en  = 1'b0;
        mem_w_addr = '0;
        mem_r_addr = '0;
        mem_w_data = '0;
        case (state_reg)
            ACCESS: begin
                mem_r_addr = aligned_addr;
                if (word_store) begin
                    mem_wr_en  = 1'b1;
                    mem_w_addr = aligned_addr;
                    mem_w_data = wdata_reg;
                end
            end
            WRITE: begin
                mem_wr_en  = 1'b1;
                mem_w_addr = aligned_addr;
                mem_w_data = merged_reg;
            end
            default: ;
        endcase
    end

    assign cpu_rsp_valid = (state_reg == RESP) && !port_reg;
    assign dbg_rsp_valid = (state_reg == RESP) &&  port_reg;
    assign cpu_rsp_rdata = cpu_rsp_valid ? rdata_reg : '0;
    assign dbg_rsp_rdata = dbg_rsp_valid ? rdata_reg : '0;
    assign cpu_rsp_err   = cpu_rsp_valid & err_reg;
    assign dbg_rsp_err   = dbg_rsp_valid & err_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            port_reg   <= 1'b0;
            we_reg     <= 1'b0;
            size_reg   <= 2'b00;
            uns_reg    <= 1'b0;
            addr_reg   <= '0;
            wdata_reg  <= '0;
            err_reg    <= 1'b0;
            rdata_reg  <= '0;
            merged_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (state_reg == IDLE && (|grant)) begin
                port_reg  <= grant[1];
                we_reg    <= sel_we;
                size_reg  <= sel_size;
                uns_reg   <= sel_uns;
                addr_reg  <= sel_addr;
                wdata_reg <= sel_wdata;
                err_reg   <= sel_err;
                rdata_reg <= '0;
            end else if (state_reg == ACCESS) begin
                if (!we_reg) begin
                    rdata_reg <= load_extend(mem_r_data, size_reg, addr_reg[1:0], uns_reg);
                end else if (!word_store) begin
                    merged_reg <= merge_lanes(mem_r_data, wdata_reg, size_reg, addr_reg[1:0]);
                end
            end
        end
    end

endmodule
